// File: rtl/mac_operand_streamer.sv
// mac_operand_streamer
// Command-driven AXIS source feeding the MAC units. Each command streams CMD_LEN
// {weight, activation} pairs read from two synchronous-read buffers, optionally
// preceded by a bias beat (TUSER=1), with TLAST on the final pair.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   CMD_*                 command handshake and fields (base addresses, length,
//                         bias, bias enable, stream ID)
//   W_RD_*, A_RD_*        weight/activation buffer read ports (data one cycle
//                         after the strobe)
//   MD_AXIS_*             operand stream to the MAC units
//   BUSY                  command in progress
//   DONE                  one-cycle completion pulse
module mac_operand_streamer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,

    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic [ADDR_WIDTH-1:0]   CMD_W_BASE,
    input  logic [ADDR_WIDTH-1:0]   CMD_A_BASE,
    input  logic [LEN_WIDTH-1:0]    CMD_LEN,
    input  logic [DATA_WIDTH-1:0]   CMD_BIAS,
    input  logic                    CMD_USE_BIAS,
    input  logic [7:0]              CMD_TID,

    output logic                    W_RD_EN,
    output logic [ADDR_WIDTH-1:0]   W_RD_ADDR,
    input  logic [DATA_WIDTH-1:0]   W_RD_DATA,
    output logic                    A_RD_EN,
    output logic [ADDR_WIDTH-1:0]   A_RD_ADDR,
    input  logic [DATA_WIDTH-1:0]   A_RD_DATA,

    output logic                    MD_AXIS_TVALID,
    output logic [2*DATA_WIDTH-1:0] MD_AXIS_TDATA,
    output logic                    MD_AXIS_TLAST,
    output logic                    MD_AXIS_TUSER,
    output logic [7:0]              MD_AXIS_TID,
    input  logic                    MD_AXIS_TREADY,

    output logic                    BUSY,
    output logic                    DONE
);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    // Beat layout inside the FIFO: {tuser, tlast, weight, activation}
    localparam int unsigned BeatW = 2 * DATA_WIDTH + 2;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
    logic [ADDR_WIDTH-1:0] a_base_q, a_base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [7:0]            tid_q, tid_d;
    logic                  inflight_q, inflight_last_q;
    logic                  done_q, done_d;
    logic                  live_q;   // low in the first cycle after reset

    logic [BeatW-1:0]      fifo_q [2];
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, wr_ptr_q;

    logic                  cmd_ready, cmd_fire;
    logic                  tvalid, pop, fifo_pop;
    logic                  push, bias_push, ret_push;
    logic                  issue, issue_last;
    logic [2:0]            occupancy;
    logic [BeatW-1:0]      ret_beat, bias_beat, head, push_beat;

    always_comb begin
        cmd_ready = live_q && (state_q == StIdle);
        cmd_fire  = CMD_VALID && cmd_ready;

        ret_beat  = {1'b0, inflight_last_q, W_RD_DATA, A_RD_DATA};
        bias_beat = {1'b1, 1'b0, {DATA_WIDTH{1'b0}}, CMD_BIAS};

        // Returning read data is presented directly when the FIFO is empty so
        // the first pair reaches the output in the cycle its data returns.
        tvalid   = (count_q != 2'd0) || inflight_q;
        head     = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : ret_beat;
        pop      = tvalid && MD_AXIS_TREADY;
        fifo_pop = pop && (count_q != 2'd0);

        // A bypassed beat accepted downstream never enters the FIFO.
        ret_push  = inflight_q && !((count_q == 2'd0) && pop);
        bias_push = cmd_fire && (CMD_LEN != '0) && CMD_USE_BIAS;
        push      = ret_push || bias_push;
        push_beat = bias_push ? bias_beat : ret_beat;

        // Slots reserved (stored + in flight) after this cycle's pop.
        occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (state_q == StStream) && (occupancy < 3'd2);
        issue_last = issue && (idx_q == len_q - LEN_WIDTH'(1));

        count_d = count_q + {1'b0, push} - {1'b0, fifo_pop};
    end

    always_comb begin
        state_d  = state_q;
        w_base_d = w_base_q;
        a_base_d = a_base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        tid_d    = tid_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    w_base_d = CMD_W_BASE;
                    a_base_d = CMD_A_BASE;
                    len_d    = CMD_LEN;
                    tid_d    = CMD_TID;
                    idx_d    = '0;
                    if (CMD_LEN == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                if (issue) begin
                    idx_d = idx_q + LEN_WIDTH'(1);
                    if (issue_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // The TLAST beat is always the last one out.
                if (pop && head[BeatW-2]) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q         <= StIdle;
            w_base_q        <= '0;
            a_base_q        <= '0;
            len_q           <= '0;
            idx_q           <= '0;
            tid_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            live_q          <= 1'b0;
            count_q         <= 2'd0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            w_base_q        <= w_base_d;
            a_base_q        <= a_base_d;
            len_q           <= len_d;
            idx_q           <= idx_d;
            tid_q           <= tid_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            done_q          <= done_d;
            live_q          <= 1'b1;
            count_q         <= count_d;
            if (fifo_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
        end
    end

    // Payload storage needs no reset; count_q qualifies it.
    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_beat;
        end
    end

    always_comb begin
        CMD_READY      = cmd_ready;
        W_RD_EN        = issue;
        A_RD_EN        = issue;
        W_RD_ADDR      = issue ? w_base_q + ADDR_WIDTH'(idx_q) : '0;
        A_RD_ADDR      = issue ? a_base_q + ADDR_WIDTH'(idx_q) : '0;
        MD_AXIS_TVALID = tvalid;
        MD_AXIS_TDATA  = tvalid ? head[2*DATA_WIDTH-1:0] : '0;
        MD_AXIS_TLAST  = tvalid && head[BeatW-2];
        MD_AXIS_TUSER  = tvalid && head[BeatW-1];
        MD_AXIS_TID    = tvalid ? tid_q : 8'h00;
        BUSY           = (state_q != StIdle);
        DONE           = done_q;
    end

endmodule
